apb_pair: RTL and testbench

Self-contained APB-style link: a single-word transfer master and a 16-word register-file slave, wired together inside one block. The host drives select, direction, address and data. The master runs the SETUP/ACCESS handshake on the internal bus; the slave stores writes and returns readback data on `PRDATA1`. The block is used as the bus-protocol reference and bring-up target for the peripheral subsystem.

---
 rtl/apb_pair.sv | 96 +++++++++
 tb/tb_apb_pair.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/apb_pair.sv
// APB-style link: single-word transfer master driving a 16 x 32 register-file slave.
// The master walks IDLE/SETUP/ACCESS. The slave completes one access per ACCESS edge.
module apb_pair (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        transfer,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PDATA,
  output logic        PENABLE,
  output logic [31:0] PRWADDR,
  output logic [31:0] PRWDATA,
  output logic        PREADY,
  output logic [31:0] PRDATA1
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_q [16];
  logic [31:0] mem_d [16];

  logic start, complete, load;
  logic [3:0] idx;

  assign start    = PSEL & transfer;
  assign PENABLE  = (state_q == ACCESS);
  // Zero-wait-state slave: ready whenever the access phase is selected.
  assign PREADY   = PSEL & PENABLE;
  assign complete = PSEL & PENABLE & PREADY;
  assign idx      = addr_q[3:0];

  assign PRWADDR = addr_q;
  assign PRWDATA = wdata_q;
  assign PRDATA1 = rdata_q;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          load    = 1'b1;
        end
      end
      SETUP: state_d = PSEL ? ACCESS : IDLE;
      ACCESS: begin
        // A dropped PSEL leaves PREADY low: abandon without completing.
        if (complete && start) begin
          state_d = SETUP;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = load ? PADDR : addr_q;
    wdata_d = load ? PDATA : wdata_q;
    rdata_d = rdata_q;
    mem_d   = mem_q;
    if (complete) begin
      if (PWRITE) begin
        mem_d[idx] = wdata_q;
        rdata_d    = wdata_q;
      end else begin
        rdata_d    = mem_q[idx];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      for (int i = 0; i < 16; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_apb_pair.sv
// Directed bench for apb_pair: stimulus pushes expected readback, a monitor pops on completion.
module tb_apb_pair;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL, transfer, PWRITE;
  logic [31:0] PADDR, PDATA;
  logic        PENABLE, PREADY;
  logic [31:0] PRWADDR, PRWDATA, PRDATA1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    string       nm;
  } exp_t;

  exp_t sb[$];
  logic comp_seen = 1'b0;

  apb_pair dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .transfer(transfer), .PWRITE(PWRITE),
    .PADDR(PADDR), .PDATA(PDATA), .PENABLE(PENABLE), .PRWADDR(PRWADDR),
    .PRWDATA(PRWDATA), .PREADY(PREADY), .PRDATA1(PRDATA1)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // A completion edge is announced by PENABLE&PREADY on the preceding negedge;
  // PRDATA1 is checked on the following negedge.
  always @(negedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      comp_seen = 1'b0;
    end else begin
      if (comp_seen) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: got PRDATA1 %08h expected no completion", PRDATA1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check(e.nm, PRDATA1, e.data);
        end
      end
      comp_seen = PENABLE & PREADY;
    end
  end

  // PSEL high 4 cycles (transfer pulsed for the first), then low 2 cycles.
  task automatic xfer(input string nm, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] exp);
    exp_t e;
    @(posedge PCLK); #1;
    PSEL = 1'b1; transfer = 1'b1; PWRITE = we; PADDR = addr; PDATA = data;
    e.data = exp; e.nm = nm;
    sb.push_back(e);
    @(posedge PCLK); #1;
    transfer = 1'b0;
    @(negedge PCLK);
    check({nm, "_setup_penable"}, {31'b0, PENABLE}, 32'd0);
    check({nm, "_setup_addr"}, PRWADDR, addr);
    @(posedge PCLK);
    @(negedge PCLK);
    check({nm, "_access_penable"}, {31'b0, PENABLE}, 32'd1);
    check({nm, "_access_pready"}, {31'b0, PREADY}, 32'd1);
    check({nm, "_access_wdata"}, PRWDATA, data);
    @(posedge PCLK);
    @(posedge PCLK); #1;
    PSEL = 1'b0;
    repeat (2) @(posedge PCLK);
  endtask

  initial begin
    exp_t e;
    PRESET = 1'b0; PSEL = 1'b0; transfer = 1'b0; PWRITE = 1'b0; PADDR = '0; PDATA = '0;
    @(posedge PCLK); #2;
    PRESET = 1'b1;
    @(negedge PCLK);
    check("rst_penable", {31'b0, PENABLE}, 32'd0);
    check("rst_pready",  {31'b0, PREADY},  32'd0);
    check("rst_prwaddr", PRWADDR, 32'd0);
    check("rst_prwdata", PRWDATA, 32'd0);
    check("rst_prdata1", PRDATA1, 32'd0);

    xfer("wr0", 1'b1, 32'h0, 32'h0000_0309, 32'h0000_0309);
    xfer("wr1", 1'b1, 32'h1, 32'h1412_2023, 32'h1412_2023);
    xfer("wr2", 1'b1, 32'h2, 32'h534D_4F4C, 32'h534D_4F4C);
    xfer("wr3", 1'b1, 32'h3, 32'h4956_414E, 32'h4956_414E);
    xfer("rd0", 1'b0, 32'h0, 32'h0, 32'h0000_0309);
    xfer("rd1", 1'b0, 32'h1, 32'h0, 32'h1412_2023);
    xfer("rd2", 1'b0, 32'h2, 32'h0, 32'h534D_4F4C);
    xfer("rd3", 1'b0, 32'h3, 32'h0, 32'h4956_414E);

    xfer("alias_wr", 1'b1, 32'h12, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    xfer("alias_rd", 1'b0, 32'h2,  32'h0, 32'hDEAD_BEEF);
    xfer("alias_rd3", 1'b0, 32'h3, 32'h0, 32'h4956_414E);

    // Abort: PSEL drops while in SETUP.
    @(posedge PCLK); #1;
    PSEL = 1'b1; transfer = 1'b1; PWRITE = 1'b1; PADDR = 32'h0; PDATA = 32'h0000_0BAD;
    @(posedge PCLK); #1;
    PSEL = 1'b0; transfer = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check("abort_penable", {31'b0, PENABLE}, 32'd0);
      check("abort_pready",  {31'b0, PREADY},  32'd0);
    end
    check("abort_prdata1", PRDATA1, 32'h4956_414E);
    xfer("abort_rd0", 1'b0, 32'h0, 32'h0, 32'h0000_0309);

    // Gating: PSEL high with transfer low never leaves IDLE.
    @(posedge PCLK); #1;
    PSEL = 1'b1; transfer = 1'b0; PWRITE = 1'b1; PADDR = 32'h1; PDATA = 32'h0000_0BAD;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      check("gate_penable", {31'b0, PENABLE}, 32'd0);
      check("gate_pready",  {31'b0, PREADY},  32'd0);
    end
    check("gate_prwaddr", PRWADDR, 32'h0);
    @(posedge PCLK); #1;
    PSEL = 1'b0;
    check("gate_prdata1", PRDATA1, 32'h0000_0309);
    xfer("gate_rd1", 1'b0, 32'h1, 32'h0, 32'h1412_2023);

    // Back-to-back: write 5, then read alias 0x15 picked up at the next SETUP.
    @(posedge PCLK); #1;
    PSEL = 1'b1; transfer = 1'b1; PWRITE = 1'b1; PADDR = 32'h5; PDATA = 32'hA5A5_0F0F;
    e.data = 32'hA5A5_0F0F; e.nm = "b2b_wr";
    sb.push_back(e);
    @(posedge PCLK); #1;
    PADDR = 32'h15; PDATA = 32'h0;
    @(posedge PCLK);
    @(negedge PCLK);
    check("b2b_access1", {31'b0, PENABLE}, 32'd1);
    @(posedge PCLK); #1;
    PWRITE = 1'b0; transfer = 1'b0;
    e.data = 32'hA5A5_0F0F; e.nm = "b2b_rd";
    sb.push_back(e);
    @(negedge PCLK);
    check("b2b_setup2", {31'b0, PENABLE}, 32'd0);
    check("b2b_addr2", PRWADDR, 32'h15);
    @(posedge PCLK);
    @(negedge PCLK);
    check("b2b_access2", {31'b0, PENABLE}, 32'd1);
    @(posedge PCLK); #1;
    PSEL = 1'b0;
    repeat (2) @(posedge PCLK);

    // Reset asserted asynchronously during ACCESS of a write that must not land.
    @(posedge PCLK); #1;
    PSEL = 1'b1; transfer = 1'b1; PWRITE = 1'b1; PADDR = 32'h4; PDATA = 32'h0000_0055;
    @(posedge PCLK); #1;
    transfer = 1'b0;
    @(posedge PCLK); #3;
    PRESET = 1'b0;
    #1;
    check("mrst_penable", {31'b0, PENABLE}, 32'd0);
    check("mrst_pready",  {31'b0, PREADY},  32'd0);
    check("mrst_prwaddr", PRWADDR, 32'd0);
    check("mrst_prwdata", PRWDATA, 32'd0);
    check("mrst_prdata1", PRDATA1, 32'd0);
    PSEL = 1'b0;
    @(posedge PCLK); #3;
    PRESET = 1'b1;
    xfer("mrst_rd0", 1'b0, 32'h0, 32'h0, 32'h0);
    xfer("mrst_rd2", 1'b0, 32'h2, 32'h0, 32'h0);
    xfer("mrst_rd4", 1'b0, 32'h4, 32'h0, 32'h0);

    repeat (3) @(posedge PCLK);
    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
